// File: rtl/restoring_divider_if.sv
// Request/response bundle for restoring_divider: start with operands in, status and results out.
interface restoring_divider_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         dbz;
  logic         ovf;

  modport master (output start, x, y, input busy, done, q, r, dbz, ovf);
  modport slave  (input start, x, y, output busy, done, q, r, dbz, ovf);
endinterface

// File: rtl/restoring_divider.sv
// Multi-cycle restoring divider, one quotient bit per cycle.
// Define DIV_SIGNED_EN for two's-complement operands; otherwise operands are unsigned.
module restoring_divider #(
  parameter int W = 8
) (
  input logic                clk,
  input logic                rst,
  restoring_divider_if.slave bus
);
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        r_state, w_next;
  logic [W-1:0]  r_dvd, r_dvs, r_acc, r_q, r_r;
  logic [CW-1:0] r_cnt;
  logic          r_dbz, r_ovf;

  logic [W-1:0]  w_x_mag, w_y_mag, w_q_fix, w_r_fix;
  logic          w_ovf_fix;
  logic          w_y_zero;
  logic [W:0]    w_shift, w_trial;

  assign w_y_zero = (bus.y == '0);
  // The trial difference is one bit wider than the operands so its MSB is a true sign.
  assign w_shift  = {r_acc, r_dvd[W-1]};
  assign w_trial  = w_shift - {1'b0, r_dvs};

`ifdef DIV_SIGNED_EN
  logic r_x_neg, r_y_neg, r_min_by_m1;

  assign w_x_mag   = bus.x[W-1] ? -bus.x : bus.x;
  assign w_y_mag   = bus.y[W-1] ? -bus.y : bus.y;
  assign w_q_fix   = (r_x_neg ^ r_y_neg) ? -r_dvd : r_dvd;
  assign w_r_fix   = r_x_neg ? -r_acc : r_acc;
  assign w_ovf_fix = r_min_by_m1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x_neg     <= 1'b0;
      r_y_neg     <= 1'b0;
      r_min_by_m1 <= 1'b0;
    end else if (r_state == IDLE && bus.start && !w_y_zero) begin
      r_x_neg     <= bus.x[W-1];
      r_y_neg     <= bus.y[W-1];
      r_min_by_m1 <= (bus.x == {1'b1, {(W-1){1'b0}}}) && (bus.y == '1);
    end
  end
`else
  assign w_x_mag   = bus.x;
  assign w_y_mag   = bus.y;
  assign w_q_fix   = r_dvd;
  assign w_r_fix   = r_acc;
  assign w_ovf_fix = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    // NOTE: default assigned first so no path through the case leaves w_next unassigned (no latch).
    w_next = r_state;
    case (r_state)
      IDLE: if (bus.start) w_next = w_y_zero ? DONE : CALC;
      CALC: if (r_cnt == CW'(W - 1)) w_next = FIX;
      FIX:  w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: all state below uses non-blocking assignment so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dvd <= '0;
      r_dvs <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_dbz <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            if (w_y_zero) begin
              r_q   <= '1;
              r_r   <= bus.x;
              r_dbz <= 1'b1;
              r_ovf <= 1'b0;
            end else begin
              r_dvd <= w_x_mag;
              r_dvs <= w_y_mag;
              r_acc <= '0;
              r_cnt <= '0;
            end
          end
        end
        CALC: begin
          // Restore on a negative trial: keep the shifted partial remainder instead.
          r_acc <= w_trial[W] ? w_shift[W-1:0] : w_trial[W-1:0];
          r_dvd <= {r_dvd[W-2:0], ~w_trial[W]};
          r_cnt <= r_cnt + CW'(1);
        end
        FIX: begin
          r_q   <= w_q_fix;
          r_r   <= w_r_fix;
          r_ovf <= w_ovf_fix;
          r_dbz <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (r_state != IDLE);
  assign bus.done = (r_state == DONE);
  assign bus.q    = r_q;
  assign bus.r    = r_r;
  assign bus.dbz  = r_dbz;
  assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider (W=8); expectations follow DIV_SIGNED_EN.
module tb_restoring_divider;
  localparam int W = 8;
`ifdef DIV_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   seen_done;

  restoring_divider_if #(.W(W)) bus ();
  restoring_divider #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.x = a;
    bus.y = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Waits (bounded) for done; n0 is the number of edges already elapsed since acceptance.
  task automatic collect(input string tag, input int n0,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edbz, input logic eovf, input int elat,
                         input bit b2b, input logic [W-1:0] nx, input logic [W-1:0] ny);
    int n = n0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " latency"}, n, elat);
    check({tag, " q"}, bus.q, eq);
    check({tag, " r"}, bus.r, er);
    check({tag, " dbz"}, bus.dbz, edbz);
    check({tag, " ovf"}, bus.ovf, eovf);
    if (b2b) begin
      bus.x = nx;
      bus.y = ny;
      bus.start = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, " done pulse"}, bus.done, 1'b0);
    check({tag, " idle"}, bus.busy, 1'b0);
    check({tag, " q hold"}, bus.q, eq);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.x = '0;
    bus.y = '0;
    #12;
    check("rst busy", bus.busy, 1'b0);
    check("rst done", bus.done, 1'b0);
    check("rst q", bus.q, 8'h00);
    check("rst r", bus.r, 8'h00);
    check("rst dbz", bus.dbz, 1'b0);
    check("rst ovf", bus.ovf, 1'b0);

    // First start on the very edge where reset is released.
    @(negedge clk);
    rst = 1'b1;
    bus.x = 8'h08;
    bus.y = 8'hFB;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("first busy", bus.busy, 1'b1);
    collect("p8_m5", 1, SGN ? 8'hFF : 8'h00, SGN ? 8'h03 : 8'h08, 1'b0, 1'b0, 10, 1'b0, '0, '0);

    launch(8'h80, 8'hFF);
    collect("min_m1", 1, SGN ? 8'h80 : 8'h00, SGN ? 8'h00 : 8'h80, 1'b0, SGN, 10, 1'b0, '0, '0);
    launch(8'hC0, 8'h20);
    collect("m64_32", 1, SGN ? 8'hFE : 8'h06, 8'h00, 1'b0, 1'b0, 10, 1'b0, '0, '0);
    launch(8'hF9, 8'h02);
    collect("m7_2", 1, SGN ? 8'hFD : 8'h7C, SGN ? 8'hFF : 8'h01, 1'b0, 1'b0, 10, 1'b0, '0, '0);
    launch(8'h7F, 8'h01);
    collect("max_1", 1, 8'h7F, 8'h00, 1'b0, 1'b0, 10, 1'b0, '0, '0);
    launch(8'hFB, 8'h08);
    collect("fb_8", 1, SGN ? 8'h00 : 8'h1F, SGN ? 8'hFB : 8'h03, 1'b0, 1'b0, 10, 1'b0, '0, '0);

    launch(8'h05, 8'h00);
    collect("dbz", 1, 8'hFF, 8'h05, 1'b1, 1'b0, 1, 1'b0, '0, '0);
    launch(8'h08, 8'h02);
    collect("after_dbz", 1, 8'h04, 8'h00, 1'b0, 1'b0, 10, 1'b0, '0, '0);

    // Start pulse and operand changes while busy must be ignored.
    launch(8'h64, 8'h07);
    @(negedge clk);
    bus.x = 8'hFF;
    bus.y = 8'h01;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    collect("busy_ign", 3, 8'h0E, 8'h02, 1'b0, 1'b0, 10, 1'b0, '0, '0);
    @(posedge clk);
    #1;
    check("no reaccept", bus.busy, 1'b0);

    // Start held high during DONE is taken on the edge after DONE.
    launch(8'h11, 8'h03);
    collect("b2b_a", 1, 8'h05, 8'h02, 1'b0, 1'b0, 10, 1'b1, 8'h20, 8'h05);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    collect("b2b_b", 1, 8'h06, 8'h02, 1'b0, 1'b0, 10, 1'b0, '0, '0);

    // Reset mid-operation clears outputs at once and suppresses done.
    launch(8'h64, 8'h07);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort busy", bus.busy, 1'b0);
    check("abort done", bus.done, 1'b0);
    check("abort q", bus.q, 8'h00);
    check("abort r", bus.r, 8'h00);
    check("abort dbz", bus.dbz, 1'b0);
    check("abort ovf", bus.ovf, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen_done = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) seen_done++;
    end
    check("abort no done", seen_done, 0);
    check("abort idle", bus.busy, 1'b0);

    launch(8'h64, 8'h07);
    collect("recover", 1, 8'h0E, 8'h02, 1'b0, 1'b0, 10, 1'b0, '0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
